// File: rtl/cpu_pkg.sv
// cpu_pkg: shared pipeline-control types for the hazard unit
package cpu_pkg;
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;
  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hazard_state_t;
  function automatic logic reg_hit(input logic we, input logic [4:0] rd, input logic [4:0] rs);
    return we && rd != 5'd0 && rd == rs;
  endfunction
endpackage

// File: rtl/forward_sel.sv
// forward_sel: picks the bypass source for one Execute operand, Memory stage first
module forward_sel
  import cpu_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rd_m,
  input  logic       reg_write_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_w,
  output fwd_sel_t   sel
);
  // younger Memory result wins over the older Writeback result
  always_comb
    sel = reg_hit(reg_write_m, rd_m, rs) ? FWD_M :
          reg_hit(reg_write_w, rd_w, rs) ? FWD_W : FWD_RF;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding, load-use/branch/memory-wait stalls and flushes, stall statistics
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic             ResultSrcE,
  input  logic             PCSrcE,
  input  logic [4:0]       RdM,
  input  logic             RegWriteM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteW,
  input  logic             MemReqM,
  input  logic             MemReady,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] StallCnt,
  output logic             MemErr
);
  localparam int WW = $clog2(TIMEOUT + 1);
  hazard_state_t state;
  logic [WW-1:0] wcnt;
  logic [WW-1:0] winc;
  logic          lw_stall;
  logic          mem_stall;
  fwd_sel_t      fa;
  fwd_sel_t      fb;
  forward_sel u_fwd_a (
    .rs          (Rs1E),
    .rd_m        (RdM),
    .reg_write_m (RegWriteM),
    .rd_w        (RdW),
    .reg_write_w (RegWriteW),
    .sel         (fa)
  );
  forward_sel u_fwd_b (
    .rs          (Rs2E),
    .rd_m        (RdM),
    .reg_write_m (RegWriteM),
    .rd_w        (RdW),
    .reg_write_w (RegWriteW),
    .sel         (fb)
  );
  assign ForwardAE = fa;
  assign ForwardBE = fb;
  // a memory wait freezes the whole pipe, so load-use and redirect effects wait until it clears
  always_comb begin
    lw_stall  = ResultSrcE && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);
    mem_stall = MemReqM && !MemReady;
    StallF    = mem_stall || lw_stall;
    StallD    = mem_stall || lw_stall;
    StallE    = mem_stall;
    StallM    = mem_stall;
    FlushW    = mem_stall;
    FlushD    = !mem_stall && PCSrcE;
    FlushE    = !mem_stall && (lw_stall || PCSrcE);
    winc      = (state == MEM_WAIT ? wcnt : '0) + WW'(1);
  end
  // wait FSM with timeout watchdog, sticky error and saturating stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      wcnt     <= '0;
      MemErr   <= 1'b0;
      StallCnt <= '0;
    end else begin
      StallCnt <= (StallF && !(&StallCnt)) ? StallCnt + CNT_W'(1) : StallCnt;
      if (mem_stall && winc == WW'(TIMEOUT)) begin
        MemErr <= 1'b1;
        state  <= RUN;
        wcnt   <= '0;
      end else begin
        state <= mem_stall ? MEM_WAIT : RUN;
        wcnt  <= mem_stall ? winc : '0;
      end
    end
  end
endmodule
